// File: rtl/fp32_pkg.sv
// ---------------------------------------------------------------------------
// fp32_pkg
// Shared definitions for the IEEE-754 single-precision blocks (int_to_float,
// float_to_int and their benches).
//   - Field positions of the 32-bit word (sign, exponent, fraction)
//   - Exponent bias and the all-ones exponent code (Inf / NaN)
//   - Converter state encoding
//   - Small field-extraction helpers
// ---------------------------------------------------------------------------
package fp32_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_MSB = 22;
    localparam int FRAC_LSB = 0;

    localparam int EXP_WIDTH  = EXP_MSB - EXP_LSB + 1;
    localparam int FRAC_WIDTH = FRAC_MSB - FRAC_LSB + 1;

    localparam int                   BIAS         = 127;
    localparam logic [EXP_WIDTH-1:0] EXP_ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [EXP_WIDTH-1:0] fp32Exp(input logic [31:0] word);
        return word[EXP_MSB:EXP_LSB];
    endfunction

    function automatic logic [FRAC_WIDTH-1:0] fp32Frac(input logic [31:0] word);
        return word[FRAC_MSB:FRAC_LSB];
    endfunction

endpackage

// File: rtl/float_to_int_if.sv
// ---------------------------------------------------------------------------
// float_to_int_if
// Handshake bundle of the float-to-unsigned-integer converter.
//   in_valid / in_ready / float_input        : input side (IEEE-754 single)
//   out_valid / out_ready / int_output       : result side
//   flag_overflow / flag_invalid / flag_inexact : exception flags, valid with
//                                               out_valid
// Modports:
//   slave  : the converter
//   master : the producer/consumer driving the converter
// ---------------------------------------------------------------------------
interface float_to_int_if #(
    parameter int INT_WIDTH = 8
);

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          float_input;
    logic                 out_valid;
    logic                 out_ready;
    logic [INT_WIDTH-1:0] int_output;
    logic                 flag_overflow;
    logic                 flag_invalid;
    logic                 flag_inexact;

    modport slave (
        input  in_valid,
        output in_ready,
        input  float_input,
        output out_valid,
        input  out_ready,
        output int_output,
        output flag_overflow,
        output flag_invalid,
        output flag_inexact
    );

    modport master (
        output in_valid,
        input  in_ready,
        output float_input,
        input  out_valid,
        output out_ready,
        input  int_output,
        input  flag_overflow,
        input  flag_invalid,
        input  flag_inexact
    );

endinterface

// File: rtl/fp32_classify.sv
// ---------------------------------------------------------------------------
// fp32_classify
// Purely combinational classifier for an IEEE-754 single-precision word.
// Ports:
//   float_i              : 32-bit IEEE-754 word
//   sign_o               : sign bit
//   is_nan_o             : exponent all ones, fraction nonzero
//   is_inf_o             : exponent all ones, fraction zero
//   is_zero_or_denorm_o  : exponent zero (covers +-0 and denormals)
//   frac_nonzero_o       : fraction field is nonzero
//   frac_o               : raw fraction field
//   unbiased_exp_o       : exponent minus bias, signed (-127..128)
// ---------------------------------------------------------------------------
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [31:0]           float_i,
    output logic                  sign_o,
    output logic                  is_nan_o,
    output logic                  is_inf_o,
    output logic                  is_zero_or_denorm_o,
    output logic                  frac_nonzero_o,
    output logic [FRAC_WIDTH-1:0] frac_o,
    output logic signed [8:0]     unbiased_exp_o
);

    logic [EXP_WIDTH-1:0]  expField;
    logic [FRAC_WIDTH-1:0] fracField;

    assign expField  = fp32Exp(float_i);
    assign fracField = fp32Frac(float_i);

    assign sign_o              = float_i[SIGN_BIT];
    assign frac_o              = fracField;
    assign frac_nonzero_o      = |fracField;
    assign is_nan_o            = (expField == EXP_ALL_ONES) && (|fracField);
    assign is_inf_o            = (expField == EXP_ALL_ONES) && !(|fracField);
    assign is_zero_or_denorm_o = (expField == '0);

    // A 9-bit signed result holds every value from 0-127 to 255-127.
    assign unbiased_exp_o = $signed({1'b0, expField}) - 9'sd127;

endmodule

// File: rtl/float_to_int.sv
// ---------------------------------------------------------------------------
// float_to_int
// Multi-cycle IEEE-754 single -> unsigned integer converter. Truncates toward
// zero and saturates; special and out-of-range inputs finish right after
// decode, in-range values are denormalised by a one-bit-per-cycle shifter.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, discards any in-flight work
//   bus_io : float_to_int_if.slave handshake bundle (input word, result and
//            overflow / invalid / inexact flags)
// Parameters:
//   INT_WIDTH : result width, legal range 1..31 (exponent bias fixed at 127)
// ---------------------------------------------------------------------------
module float_to_int
    import fp32_pkg::*;
#(
    parameter int INT_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    float_to_int_if.slave  bus_io
);

    // {hidden one, fraction, padding}; padding lets INT_WIDTH exceed 24.
    localparam int MANT_EXT_WIDTH = 1 + FRAC_WIDTH + 32;

    state_t                 state_q;
    logic                   inReady_q;
    logic                   outValid_q;
    logic [31:0]            float_q;
    logic [INT_WIDTH-1:0]   shiftReg_q;
    logic [4:0]             count_q;
    logic                   sticky_q;
    logic [INT_WIDTH-1:0]   result_q;
    logic                   overflow_q;
    logic                   invalid_q;
    logic                   inexact_q;

    logic                   sign;
    logic                   isNan;
    logic                   isInf;
    logic                   isZeroOrDenorm;
    logic                   fracNonzero;
    logic [FRAC_WIDTH-1:0]  frac;
    logic signed [8:0]      unbiasedExp;

    logic [MANT_EXT_WIDTH-1:0] mantExt;
    logic [MANT_EXT_WIDTH-1:0] lowBits;
    int                        kInt;
    int                        nShift;

    state_t                 decState_d;
    logic [INT_WIDTH-1:0]   decResult_d;
    logic                   decOverflow_d;
    logic                   decInvalid_d;
    logic                   decInexact_d;
    logic [INT_WIDTH-1:0]   decShift_d;
    logic                   decSticky_d;
    logic [4:0]             decCount_d;

    fp32_classify u_classify (
        .float_i             (float_q),
        .sign_o              (sign),
        .is_nan_o            (isNan),
        .is_inf_o            (isInf),
        .is_zero_or_denorm_o (isZeroOrDenorm),
        .frac_nonzero_o      (fracNonzero),
        .frac_o              (frac),
        .unbiased_exp_o      (unbiasedExp)
    );

    assign bus_io.in_ready      = inReady_q;
    assign bus_io.out_valid     = outValid_q;
    assign bus_io.int_output    = result_q;
    assign bus_io.flag_overflow = overflow_q;
    assign bus_io.flag_invalid  = invalid_q;
    assign bus_io.flag_inexact  = inexact_q;

    // Decode of the latched word. Case priority: NaN, infinities, zero and
    // denormals, negative normals, below one, too large, then the in-range
    // case which seeds the shifter. The top INT_WIDTH bits of the extended
    // mantissa are the integer value scaled by 2^(INT_WIDTH-1-k); everything
    // below them is already lost fraction and starts the sticky bit.
    always_comb begin
        decState_d    = DONE;
        decResult_d   = '0;
        decOverflow_d = 1'b0;
        decInvalid_d  = 1'b0;
        decInexact_d  = 1'b0;
        decShift_d    = '0;
        decSticky_d   = 1'b0;
        decCount_d    = '0;

        mantExt = {1'b1, frac, 32'b0};
        lowBits = mantExt << INT_WIDTH;
        kInt    = int'(unbiasedExp);
        nShift  = INT_WIDTH - 1 - kInt;

        if (isNan) begin
            decInvalid_d = 1'b1;
        end else if (isInf) begin
            if (sign) begin
                decInvalid_d = 1'b1;
            end else begin
                decOverflow_d = 1'b1;
                decResult_d   = '1;
            end
        end else if (isZeroOrDenorm) begin
            if (fracNonzero) begin
                decInvalid_d = sign;
                decInexact_d = !sign;
            end
        end else if (sign) begin
            decInvalid_d = 1'b1;
        end else if (kInt < 0) begin
            decInexact_d = 1'b1;
        end else if (kInt >= INT_WIDTH) begin
            decOverflow_d = 1'b1;
            decResult_d   = '1;
        end else begin
            decShift_d   = mantExt[MANT_EXT_WIDTH-1 -: INT_WIDTH];
            decSticky_d  = |lowBits;
            decCount_d   = 5'(nShift);
            decResult_d  = decShift_d;
            decInexact_d = decSticky_d;
            decState_d   = (nShift == 0) ? DONE : SHIFT;
        end
    end

    // Converter FSM. All outputs are registered here. The result and flags
    // are written only on the way into DONE, so they stay put for as long as
    // the consumer stalls. A finished result returns to IDLE before the next
    // word can be accepted, keeping one conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            float_q    <= '0;
            shiftReg_q <= '0;
            count_q    <= '0;
            sticky_q   <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            invalid_q  <= 1'b0;
            inexact_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus_io.in_valid && inReady_q) begin
                        float_q    <= bus_io.float_input;
                        inReady_q  <= 1'b0;
                        overflow_q <= 1'b0;
                        invalid_q  <= 1'b0;
                        inexact_q  <= 1'b0;
                        state_q    <= DECODE;
                    end
                end

                DECODE: begin
                    shiftReg_q <= decShift_d;
                    sticky_q   <= decSticky_d;
                    count_q    <= decCount_d;
                    if (decState_d == DONE) begin
                        result_q   <= decResult_d;
                        overflow_q <= decOverflow_d;
                        invalid_q  <= decInvalid_d;
                        inexact_q  <= decInexact_d;
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        state_q    <= SHIFT;
                    end
                end

                SHIFT: begin
                    shiftReg_q <= shiftReg_q >> 1;
                    sticky_q   <= sticky_q | shiftReg_q[0];
                    count_q    <= count_q - 5'd1;
                    if (count_q == 5'd1) begin
                        result_q   <= shiftReg_q >> 1;
                        inexact_q  <= sticky_q | shiftReg_q[0];
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end

                DONE: begin
                    if (bus_io.out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_int.sv
// ---------------------------------------------------------------------------
// tb_float_to_int
// Self-checking bench for float_to_int with INT_WIDTH = 8. Expected results,
// flags and latency come from an arithmetic reference model of the
// truncate/saturate conversion; round-trip words come from a behavioural
// integer-to-float model.
// ---------------------------------------------------------------------------
module tb_float_to_int;

    localparam int W = 8;

    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_OVF  = 3'b100;
    localparam logic [2:0] F_INV  = 3'b010;
    localparam logic [2:0] F_INX  = 3'b001;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    float_to_int_if #(.INT_WIDTH(W)) bus ();

    float_to_int #(.INT_WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference conversion: value = 1.f * 2^(e-127), truncated toward zero,
    // saturated at 2^W-1. Latency is the cycle (accept = cycle 0) in which
    // out_valid first appears: 2 for anything settled at decode, otherwise
    // 2 plus one cycle per bit position the mantissa still has to move.
    function automatic void refConvert(input logic [31:0] w,
                                       output logic [W-1:0] res,
                                       output logic [2:0] flg,
                                       output int lat);
        bit      s;
        int      e;
        longint  f;
        longint  m;
        int      k;
        s   = w[31];
        e   = int'(w[30:23]);
        f   = longint'(w[22:0]);
        res = '0;
        flg = F_NONE;
        lat = 2;
        if (e == 255) begin
            if (f != 0 || s) begin
                flg = F_INV;
            end else begin
                flg = F_OVF;
                res = '1;
            end
        end else if (e == 0) begin
            if (f != 0) flg = s ? F_INV : F_INX;
        end else if (s) begin
            flg = F_INV;
        end else begin
            k = e - 127;
            m = (longint'(1) << 23) + f;
            if (k < 0) begin
                flg = F_INX;
            end else if (k >= W) begin
                flg = F_OVF;
                res = '1;
            end else begin
                res = W'(m >> (23 - k));
                if ((m % (longint'(1) << (23 - k))) != 0) flg = F_INX;
                lat = (W - 1 - k) + 2;
            end
        end
    endfunction

    // Behavioural int_to_float for small unsigned integers (exact).
    function automatic logic [31:0] intToFloat(input int value);
        int msb;
        logic [31:0] word;
        if (value == 0) return 32'h0;
        msb = 0;
        for (int b = 0; b < 31; b++) if (((value >> b) & 1) != 0) msb = b;
        word        = '0;
        word[30:23] = 8'(127 + msb);
        word[22:0]  = 23'((longint'(value) << (23 - msb)) - (longint'(1) << 23));
        return word;
    endfunction

    // Drives one word through the handshake and collects the result.
    // Latency counts cycles after the accept edge (accept = cycle 0).
    task automatic runConversion(input logic [31:0] w,
                                 output logic [W-1:0] res,
                                 output logic [2:0] flg,
                                 output int lat,
                                 output bit timedOut);
        int guard;
        guard    = 0;
        timedOut = 1'b0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.float_input = w;
        bus.in_valid    = 1'b1;
        @(posedge clk); #1;
        bus.in_valid    = 1'b0;
        bus.float_input = $urandom();
        lat = 1;
        while (!bus.out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) timedOut = 1'b1;
        res = bus.int_output;
        flg = {bus.flag_overflow, bus.flag_invalid, bus.flag_inexact};
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.float_input = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        checks++;
        if (bus.int_output !== '0) begin
            failures++;
            $display("[TB] FAIL reset_int_output got=%0d want=0", bus.int_output);
        end
        checks++;
        if ({bus.flag_overflow, bus.flag_invalid, bus.flag_inexact} !== F_NONE) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b want=000",
                     {bus.flag_overflow, bus.flag_invalid, bus.flag_inexact});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [31:0] words [14];
        logic [W-1:0] res, expRes;
        logic [2:0]   flg, expFlg;
        int           lat, expLat;
        bit           to;
        words = '{32'h40A00000, 32'h437F0000, 32'h43800000, 32'hBF800000,
                  32'h7FC00000, 32'h80000000, 32'h40B00000, 32'h3F000000,
                  32'h3F800000, 32'h7F800000, 32'hFF800000, 32'h00000001,
                  32'h80400000, 32'h00000000};
        foreach (words[i]) begin
            refConvert(words[i], expRes, expFlg, expLat);
            runConversion(words[i], res, flg, lat, to);
            checks++;
            if (to || res !== expRes) begin
                failures++;
                $display("[TB] FAIL directed_result word=%h got=%0d want=%0d timeout=%0d",
                         words[i], res, expRes, to);
            end
            checks++;
            if (flg !== expFlg) begin
                failures++;
                $display("[TB] FAIL directed_flags word=%h got=%b want=%b", words[i], flg, expFlg);
            end
            checks++;
            if (lat !== expLat) begin
                failures++;
                $display("[TB] FAIL directed_latency word=%h got=%0d want=%0d", words[i], lat, expLat);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0]  w;
        logic [W-1:0] res, expRes;
        logic [2:0]   flg, expFlg;
        int           lat, expLat;
        bit           to;
        for (int n = 0; n < 200; n++) begin
            if ((n % 4) == 0) begin
                w = $urandom();
            end else begin
                // Mostly exponents straddling the integer range of W bits.
                w        = '0;
                w[31]    = ($urandom_range(0, 9) == 0);
                w[30:23] = 8'($urandom_range(118, 137));
                w[22:0]  = 23'($urandom());
                if ($urandom_range(0, 3) == 0) w[15:0] = '0;
            end
            refConvert(w, expRes, expFlg, expLat);
            runConversion(w, res, flg, lat, to);
            checks++;
            if (to || res !== expRes || flg !== expFlg || lat !== expLat) begin
                failures++;
                $display("[TB] FAIL random word=%h got=%0d/%b/%0d want=%0d/%b/%0d timeout=%0d",
                         w, res, flg, lat, expRes, expFlg, expLat, to);
            end
        end
    endtask

    task automatic test_backpressure;
        int           guard;
        logic [W-1:0] res;
        logic [2:0]   flg;
        int           lat;
        bit           to;
        bus.float_input = 32'h40A00000;
        bus.in_valid    = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (!bus.out_valid) begin
            failures++;
            $display("[TB] FAIL backpressure_start got=out_valid 0 want=1 within 40 cycles");
        end
        for (int c = 0; c < 10; c++) begin
            bus.in_valid    = (c % 2) == 0;
            bus.float_input = 32'h40400000;
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.int_output !== W'(5) ||
                {bus.flag_overflow, bus.flag_invalid, bus.flag_inexact} !== F_NONE) begin
                failures++;
                $display("[TB] FAIL backpressure_hold cycle=%0d got=v%b r%b %0d %b want=v1 r0 5 000",
                         c, bus.out_valid, bus.in_ready, bus.int_output,
                         {bus.flag_overflow, bus.flag_invalid, bus.flag_inexact});
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL backpressure_release got=%b want=0", bus.out_valid);
        end
        // 3.0 proves the pulses above were not captured as a pending word.
        runConversion(32'h40400000, res, flg, lat, to);
        checks++;
        if (to || res !== W'(3) || flg !== F_NONE || lat !== 8) begin
            failures++;
            $display("[TB] FAIL backpressure_next got=%0d/%b/%0d want=3/000/8 timeout=%0d",
                     res, flg, lat, to);
        end
    endtask

    task automatic test_round_trip;
        logic [W-1:0] res;
        logic [2:0]   flg;
        int           lat;
        bit           to;
        int           bad;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            runConversion(intToFloat(i), res, flg, lat, to);
            checks++;
            if (to || res !== W'(i) || flg !== F_NONE) begin
                failures++;
                bad++;
                if (bad < 10)
                    $display("[TB] FAIL round_trip i=%0d word=%h got=%0d/%b want=%0d/000",
                             i, intToFloat(i), res, flg, i);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] res;
        logic [2:0]   flg;
        int           lat;
        bit           seen;
        bit           to;
        bus.float_input = 32'h3F800000;
        bus.in_valid    = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        // Decode edge, then two shift edges: the word is mid-shift here.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_state got=r%b v%b want=r1 v0", bus.in_ready, bus.out_valid);
        end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("[TB] FAIL reset_mid_discard got=out_valid seen want=none");
        end
        runConversion(32'h40E00000, res, flg, lat, to);
        checks++;
        if (to || res !== W'(7) || flg !== F_NONE || lat !== 7) begin
            failures++;
            $display("[TB] FAIL reset_mid_next got=%0d/%b/%0d want=7/000/7 timeout=%0d",
                     res, flg, lat, to);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_round_trip();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
